// File: rtl/mxu_seq.sv
// mxu_seq: register-mapped sequential SIZE x SIZE signed matrix multiplier, C = A*B, one MAC per cycle.
// Optional feature macro MXU_SEQ_ACCUM_EN: CTRL/STATUS bit3 selects accumulate-into-C writeback.
module mxu_seq #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic              done_irq
);

   localparam int unsigned ACC_W = 2*DATA_W + $clog2(SIZE);
   localparam int unsigned IDX_W = $clog2(SIZE);
   localparam int unsigned NELEM = SIZE*SIZE;
   localparam int unsigned NW    = $clog2(NELEM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE-1);
   localparam logic [8:0]       NELEM_9  = 9'(NELEM);

   typedef enum logic {S_IDLE, S_MAC} state_t;
   state_t state_q, state_d;

   logic signed [DATA_W-1:0] a_mem [NELEM];
   logic signed [DATA_W-1:0] b_mem [NELEM];
   logic signed [ACC_W-1:0]  c_mem [NELEM];

   logic [IDX_W-1:0]        i_q, j_q, k_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    done_q, err_q;

   logic              busy_c, wr_ctrl_c, wr_fire_c, wr_in_rng_c;
   logic              start_c, clr_done_c, clr_err_c, last_k_c, last_c, accum_c;
   logic [NW-1:0]     wr_idx_c, rd_idx_c, a_idx_c, b_idx_c, c_idx_c;
   logic              rd_in_rng_c;
   logic signed [ACC_W-1:0] prod_c, acc_next_c, wb_c;
   logic [31:0]       rd_val_c;
   logic              unused_c;

   // Host write decode; only CTRL stays writable while the engine runs
   assign busy_c      = (state_q == S_MAC);
   assign wr_ctrl_c   = (awaddr[9:0] == 10'h000);
   assign wready      = !busy_c || wr_ctrl_c;
   assign wr_fire_c   = wvalid && wready;
   assign wr_in_rng_c = {1'b0, awaddr[7:0]} < NELEM_9;
   assign wr_idx_c    = NW'(awaddr[7:0]);
   assign start_c     = wr_fire_c && wr_ctrl_c && wdata[0];
   assign clr_done_c  = wr_fire_c && wr_ctrl_c && wdata[1];
   assign clr_err_c   = wr_fire_c && wr_ctrl_c && wdata[2];

   assign unused_c = ^{awaddr[ADDR_W-1:10], araddr[ADDR_W-1:10], wdata[DATA_W-1:3]};

   // MAC datapath
   assign last_k_c   = (k_q == LAST_IDX);
   assign last_c     = busy_c && last_k_c && (j_q == LAST_IDX) && (i_q == LAST_IDX);
   assign a_idx_c    = NW'(i_q) * NW'(SIZE) + NW'(k_q);
   assign b_idx_c    = NW'(k_q) * NW'(SIZE) + NW'(j_q);
   assign c_idx_c    = NW'(i_q) * NW'(SIZE) + NW'(j_q);
   assign prod_c     = ACC_W'(a_mem[a_idx_c]) * ACC_W'(b_mem[b_idx_c]);
   assign acc_next_c = acc_q + prod_c;

`ifdef MXU_SEQ_ACCUM_EN
   logic accum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accum_q <= 1'b0;
      end else if (start_c && !busy_c) begin
         accum_q <= wdata[3];
      end
   end

   assign accum_c = accum_q;
   assign wb_c    = accum_q ? (c_mem[c_idx_c] + acc_next_c) : acc_next_c;
`else
   assign accum_c = 1'b0;
   assign wb_c    = acc_next_c;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_c) state_d = S_MAC;
         S_MAC:   if (last_c)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Loop counters walk k fastest, then j, then i
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         acc_q <= '0;
      end else if (!busy_c) begin
         if (start_c) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
         end
      end else if (last_k_c) begin
         acc_q <= '0;
         k_q   <= '0;
         if (j_q == LAST_IDX) begin
            j_q <= '0;
            i_q <= (i_q == LAST_IDX) ? '0 : i_q + IDX_W'(1);
         end else begin
            j_q <= j_q + IDX_W'(1);
         end
      end else begin
         acc_q <= acc_next_c;
         k_q   <= k_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NELEM; n++) begin
            a_mem[n] <= '0;
            b_mem[n] <= '0;
         end
      end else if (wr_fire_c && wr_in_rng_c) begin
         if (awaddr[9:8] == 2'd1)      a_mem[wr_idx_c] <= wdata;
         else if (awaddr[9:8] == 2'd2) b_mem[wr_idx_c] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NELEM; n++) c_mem[n] <= '0;
      end else if (busy_c && last_k_c) begin
         c_mem[c_idx_c] <= wb_c;
      end
   end

   // Completion beats a same-cycle clear_done; a start while busy only flags err
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         done_irq <= 1'b0;
      end else begin
         done_irq <= last_c;
         if (last_c)                                   done_q <= 1'b1;
         else if ((start_c && !busy_c) || clr_done_c) done_q <= 1'b0;
         if (start_c && busy_c) err_q <= 1'b1;
         else if (clr_err_c)    err_q <= 1'b0;
      end
   end

   assign rd_in_rng_c = {1'b0, araddr[7:0]} < NELEM_9;
   assign rd_idx_c    = NW'(araddr[7:0]);

   always_comb begin
      rd_val_c = '0;
      if (araddr[9:0] == 10'h000)
         rd_val_c = {28'b0, accum_c, err_q, done_q, busy_c};
      else if (araddr[9:8] == 2'd3 && rd_in_rng_c)
         rd_val_c = 32'(c_mem[rd_idx_c]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= arvalid;
         rdata  <= arvalid ? rd_val_c : '0;
      end
   end

endmodule
